udp_unwrap: RTL and testbench

//  Receive-side counterpart of the UDP encapsulation path. Takes a 32-bit word stream
//  {src,dst} / {len,csum} / payload..., validates the 8-byte header and forwards payload only.

---
 rtl/udp_pkg.sv | 23 ++
 rtl/udp_csum.sv | 16 +
 rtl/udp_unwrap.sv | 147 ++++++++++++++
 tb/tb_udp_unwrap.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// Shared UDP definitions for the encapsulation (TX) and unwrap (RX) paths.
package udp_pkg;

  localparam logic [15:0] UDP_PROTO     = 16'h0011;
  localparam int          UDP_HDR_BYTES = 8;
  localparam int          CNT_W         = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR2,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_LEN   = 3'd1,
    ERR_CSUM  = 3'd2,
    ERR_PORT  = 3'd3,
    ERR_TRUNC = 3'd4
  } err_t;

endpackage

// File: rtl/udp_csum.sv
// Header checksum: inverted 16-bit sum of src, dst, protocol and len, carries dropped.
module udp_csum
  import udp_pkg::*;
(
  input  logic [15:0] src,
  input  logic [15:0] dst,
  input  logic [15:0] len,
  output logic [15:0] csum
);

  logic [15:0] sum;

  assign sum  = src + dst + UDP_PROTO + len;
  assign csum = ~sum;

endmodule

// File: rtl/udp_unwrap.sv
// RX UDP header check and payload forwarder; per-packet ok/err pulses, all outputs registered.
module udp_unwrap
  import udp_pkg::*;
#(
  parameter logic [15:0] LOCAL_PORT = 16'h0002,
  parameter bit          CHECK_PORT = 1'b1,
  parameter logic [15:0] MAX_LEN    = 16'd1480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        dval_in,
  input  logic        sop_in,
  output logic [31:0] payload_out,
  output logic        payload_valid,
  output logic        payload_last,
  output logic [15:0] src_port,
  output logic        hdr_valid,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [2:0]  err_code
);

  state_t             state_q, state_d;
  err_t               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_load;
  logic [15:0]        src_q, src_d, dst_q, dst_d;
  logic [15:0]        src_port_d, len_w, csum_calc;
  logic [31:0]        pl_d;
  logic               pv_d, plast_d, hv_d, ok_d, perr_d;
  logic               len_bad, csum_bad, port_bad;

  udp_csum u_csum (
    .src  (src_q),
    .dst  (dst_q),
    .len  (len_w),
    .csum (csum_calc)
  );

  assign len_w    = data_in[31:16];
  assign len_bad  = (len_w < 16'(UDP_HDR_BYTES)) || (len_w[1:0] != 2'b00) || (len_w > MAX_LEN);
  assign csum_bad = (csum_calc != data_in[15:0]);
  assign port_bad = CHECK_PORT && (dst_q != LOCAL_PORT);
  // Only consulted once len passed validation, so it always fits CNT_W.
  assign cnt_load = CNT_W'((len_w - 16'(UDP_HDR_BYTES)) >> 2);

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    dst_d      = dst_q;
    src_port_d = src_port;
    pl_d       = payload_out;
    pv_d       = 1'b0;
    plast_d    = 1'b0;
    hv_d       = 1'b0;
    ok_d       = 1'b0;
    perr_d     = 1'b0;
    if (dval_in) begin
      if (sop_in) begin
        // A sop always restarts parsing; an unfinished good packet is reported as truncated.
        src_d   = data_in[31:16];
        dst_d   = data_in[15:0];
        state_d = ST_HDR2;
        err_d   = ERR_NONE;
        if (state_q == ST_HDR2 || state_q == ST_PAYLOAD) begin
          perr_d = 1'b1;
          err_d  = ERR_TRUNC;
        end
      end else begin
        case (state_q)
          ST_HDR2: begin
            if (len_bad) begin
              perr_d  = 1'b1;
              err_d   = ERR_LEN;
              state_d = ST_IDLE;
            end else if (csum_bad || port_bad) begin
              perr_d  = 1'b1;
              err_d   = csum_bad ? ERR_CSUM : ERR_PORT;
              cnt_d   = cnt_load;
              state_d = (cnt_load == '0) ? ST_IDLE : ST_DROP;
            end else begin
              hv_d       = 1'b1;
              src_port_d = src_q;
              cnt_d      = cnt_load;
              if (cnt_load == '0) begin
                ok_d    = 1'b1;
                state_d = ST_IDLE;
              end else begin
                state_d = ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            pv_d  = 1'b1;
            pl_d  = data_in;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              plast_d = 1'b1;
              ok_d    = 1'b1;
              state_d = ST_IDLE;
            end
          end
          ST_DROP: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      err_q         <= ERR_NONE;
      cnt_q         <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      src_port      <= '0;
      payload_out   <= '0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      hdr_valid     <= 1'b0;
      pkt_ok        <= 1'b0;
      pkt_err       <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      src_port      <= src_port_d;
      payload_out   <= pl_d;
      payload_valid <= pv_d;
      payload_last  <= plast_d;
      hdr_valid     <= hv_d;
      pkt_ok        <= ok_d;
      pkt_err       <= perr_d;
    end
  end

  assign err_code = err_q;

endmodule

// File: tb/tb_udp_unwrap.sv
// Random + directed packet stimulus into two DUTs (port filter on/off) with a packet-level scoreboard.
module tb_udp_unwrap;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_in = '0;
  logic        dval_in = 1'b0;
  logic        sop_in = 1'b0;

  logic [31:0] po [2];
  logic        pv [2];
  logic        pl [2];
  logic [15:0] sp [2];
  logic        hv [2];
  logic        ok [2];
  logic        er [2];
  logic [2:0]  ec [2];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        pv;
    logic [31:0] pd;
    logic        pl, hv, ok, er;
    logic [2:0]  ec;
    logic [15:0] sp;
  } ev_t;

  ev_t         q0[$];
  ev_t         q1[$];
  bit          pend [2];
  logic [15:0] lsp  [2];

  always #5 clk = ~clk;

  udp_unwrap #(.CHECK_PORT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dval_in(dval_in), .sop_in(sop_in),
    .payload_out(po[0]), .payload_valid(pv[0]), .payload_last(pl[0]), .src_port(sp[0]),
    .hdr_valid(hv[0]), .pkt_ok(ok[0]), .pkt_err(er[0]), .err_code(ec[0]));

  udp_unwrap #(.CHECK_PORT(1'b0)) u_dut_np (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dval_in(dval_in), .sop_in(sop_in),
    .payload_out(po[1]), .payload_valid(pv[1]), .payload_last(pl[1]), .src_port(sp[1]),
    .hdr_valid(hv[1]), .pkt_ok(ok[1]), .pkt_err(er[1]), .err_code(ec[1]));

  function automatic ev_t blank(input int m);
    ev_t e;
    e.pv = 0; e.pd = '0; e.pl = 0; e.hv = 0; e.ok = 0; e.er = 0; e.ec = '0; e.sp = lsp[m];
    return e;
  endfunction

  function automatic void push(input int m, input ev_t e);
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic void push_err(input int m, input logic [2:0] code);
    ev_t e;
    e = blank(m); e.er = 1; e.ec = code;
    push(m, e);
  endfunction

  task automatic drive(input logic [31:0] w, input logic s);
    @(posedge clk); #1;
    data_in = w; dval_in = 1'b1; sop_in = s;
  endtask

  task automatic stalls(input int maxn);
    repeat ($urandom_range(0, maxn)) begin
      @(posedge clk); #1;
      data_in = $urandom; dval_in = 1'b0; sop_in = 1'($urandom);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    dval_in = 1'b0; sop_in = 1'b0;
  endtask

  // Reference: a packet's outcome follows from its header fields; events are queued before the words go out.
  task automatic send_pkt(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                          input logic [15:0] csum, input bit hdr_sent, input int n_sent);
    logic [31:0] pw [16];
    bit          lenbad;
    int          npay, s;
    logic [15:0] calc;
    ev_t         e;
    for (int i = 0; i < 16; i++) pw[i] = $urandom;
    lenbad = (len < 8) || (len % 4 != 0) || (len > 1480);
    npay   = lenbad ? 0 : (int'(len) - 8) / 4;
    s      = int'(src) + int'(dst) + 17 + int'(len);
    calc   = 16'(~s);
    for (int m = 0; m < 2; m++) begin
      if (pend[m]) begin push_err(m, 3'd4); pend[m] = 0; end
      if (!hdr_sent) begin pend[m] = 1; continue; end
      if (lenbad)                          push_err(m, 3'd1);
      else if (calc != csum)               push_err(m, 3'd2);
      else if (m == 0 && dst != 16'h0002)  push_err(m, 3'd3);
      else begin
        lsp[m] = src;
        e = blank(m); e.hv = 1; e.ok = (npay == 0);
        push(m, e);
        for (int i = 0; i < n_sent && i < npay; i++) begin
          e = blank(m); e.pv = 1; e.pd = pw[i];
          if (i == npay - 1) begin e.pl = 1; e.ok = 1; end
          push(m, e);
        end
        if (n_sent < npay) pend[m] = 1;
      end
    end
    drive({src, dst}, 1'b1);
    if (hdr_sent) begin
      stalls(2);
      drive({len, csum}, 1'b0);
      for (int i = 0; i < n_sent && i < 16; i++) begin
        stalls(2);
        drive(pw[i], 1'b0);
      end
    end
    go_idle();
  endtask

  // Non-sop words between packets must be ignored while every DUT is idle or dropping.
  task automatic strays();
    if (!pend[0] && !pend[1]) begin
      repeat ($urandom_range(0, 2)) drive($urandom, 1'b0);
      go_idle();
    end
  endtask

  task automatic check_dut(input int m);
    ev_t e;
    bit  bad;
    if (!(pv[m] || pl[m] || hv[m] || ok[m] || er[m])) return;
    n_tests++;
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL dut%0d unexpected_output: got pv=%b pd=%h pl=%b hv=%b ok=%b err=%b code=%0d, want no output",
               m, pv[m], po[m], pl[m], hv[m], ok[m], er[m], ec[m]);
      return;
    end
    e = (m == 0) ? q0.pop_front() : q1.pop_front();
    bad = (e.pv != pv[m]) || (e.pv && e.pd != po[m]) || (e.pl != pl[m]) || (e.hv != hv[m]) ||
          (e.ok != ok[m]) || (e.er != er[m]) || (e.er && e.ec != ec[m]) || (e.sp != sp[m]);
    if (bad) begin
      n_fail++;
      $display("FAIL dut%0d event: got pv=%b pd=%h pl=%b hv=%b ok=%b err=%b code=%0d sp=%h, want pv=%b pd=%h pl=%b hv=%b ok=%b err=%b code=%0d sp=%h",
               m, pv[m], po[m], pl[m], hv[m], ok[m], er[m], ec[m], sp[m],
               e.pv, e.pd, e.pl, e.hv, e.ok, e.er, e.ec, e.sp);
    end
  endtask

  task automatic check_zero(input int m, input string name);
    n_tests++;
    if (po[m] != 0 || pv[m] || pl[m] || sp[m] != 0 || hv[m] || ok[m] || er[m] || ec[m] != 0) begin
      n_fail++;
      $display("FAIL dut%0d %s: got pd=%h pv=%b pl=%b sp=%h hv=%b ok=%b err=%b code=%0d, want all zero",
               m, name, po[m], pv[m], pl[m], sp[m], hv[m], ok[m], er[m], ec[m]);
    end
  endtask

  task automatic check_drained(input string name);
    repeat (4) @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if ((m == 0 ? q0.size() : q1.size()) != 0) begin
        n_fail++;
        $display("FAIL dut%0d %s: got %0d events still pending, want 0", m, name,
                 (m == 0 ? q0.size() : q1.size()));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_dut(0);
      check_dut(1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] src, dst, len, csum;
    int          s, np, n, r;
    bit          hdr;
    for (int m = 0; m < 2; m++) begin pend[m] = 0; lsp[m] = '0; end
    #22;
    check_zero(0, "reset_state");
    check_zero(1, "reset_state");
    @(negedge clk); rst_n = 1'b1;

    send_pkt(16'h0001, 16'h0002, 16'h000C, 16'hFFDF, 1, 1);   // good, 1 payload word
    send_pkt(16'h0001, 16'h0002, 16'h000C, 16'hFFDE, 1, 1);   // bad csum
    send_pkt(16'h0001, 16'h0002, 16'h000C, 16'hFFDF, 1, 1);   // recovers
    send_pkt(16'h0001, 16'h0002, 16'h000A, 16'hFFE1, 1, 0);   // bad len
    strays();
    send_pkt(16'h0001, 16'h0003, 16'h000C, 16'hFFDE, 1, 1);   // port filter only on dut0
    send_pkt(16'h0001, 16'h0002, 16'h0014, 16'hFFD7, 1, 1);   // truncated after 1 of 3
    send_pkt(16'h0001, 16'h0002, 16'h0014, 16'hFFD7, 1, 3);   // full 3-word payload with stalls
    send_pkt(16'h0001, 16'h0002, 16'h0008, 16'hFFE3, 1, 0);   // header only
    send_pkt(16'h0005, 16'h0002, 16'h0000, 16'h0000, 0, 0);   // w0 only, aborted by next sop
    send_pkt(16'h1234, 16'h0002, 16'd1484, 16'(~(32'h1234 + 2 + 17 + 1484)), 1, 2);
    send_pkt(16'h4321, 16'h0002, 16'd1480, 16'(~(32'h4321 + 2 + 17 + 1480)), 1, 3);

    for (int k = 0; k < 150; k++) begin
      src = 16'($urandom);
      dst = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0002;
      r   = $urandom_range(0, 9);
      if (r == 0) begin
        case ($urandom_range(0, 3))
          0:       len = 16'($urandom_range(0, 7));
          1:       len = 16'h000A;
          2:       len = 16'd1484;
          default: len = 16'hFFFC;
        endcase
      end else if (r == 9) len = 16'd1480;
      else                 len = 16'(8 + 4 * $urandom_range(0, 8));
      s    = int'(src) + int'(dst) + 17 + int'(len);
      csum = 16'(~s);
      if ($urandom_range(0, 5) == 0) csum = csum ^ (16'h1 << $urandom_range(0, 15));
      hdr = ($urandom_range(0, 9) != 0);
      if (len >= 8 && len % 4 == 0 && len <= 1480) begin
        np = (int'(len) - 8) / 4;
        if ($urandom_range(0, 4) == 0 && np > 0) n = $urandom_range(0, np - 1);
        else                                     n = np;
        if (n > 16) n = $urandom_range(0, 16);
      end else begin
        n = $urandom_range(0, 4);
      end
      send_pkt(src, dst, len, csum, hdr, n);
      strays();
    end
    send_pkt(16'h00AA, 16'h0002, 16'h0010, 16'(~(32'h00AA + 2 + 17 + 16)), 1, 2);
    check_drained("drain_random");

    // Reset while a payload word is being presented.
    send_pkt(16'h0777, 16'h0002, 16'h0014, 16'(~(32'h0777 + 2 + 17 + 20)), 1, 2);
    #1 rst_n = 1'b0;
    #1;
    check_zero(0, "reset_mid_payload");
    check_zero(1, "reset_mid_payload");
    q0.delete(); q1.delete();
    for (int m = 0; m < 2; m++) begin pend[m] = 0; lsp[m] = '0; end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    send_pkt(16'h0009, 16'h0002, 16'h000C, 16'(~(32'h0009 + 2 + 17 + 12)), 1, 1);
    check_drained("drain_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
